// File: rtl/wide_add_seq.sv
// Multi-word add sequencer: streams WORDS x 32-bit slices LSB-first through one external
// 32-bit adder, chaining its carry. Define WIDE_ADD_SUB_EN to add the in_sub subtract mode.
module wide_add_seq #(
   parameter int WORDS = 4,
   parameter int W     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W*WORDS-1:0]   in_a,
   input  logic [W*WORDS-1:0]   in_b,
   input  logic                 in_cin,
`ifdef WIDE_ADD_SUB_EN
   input  logic                 in_sub,
`endif
   output logic [W-1:0]         add_a,
   output logic [W-1:0]         add_b,
   output logic                 add_cin,
   input  logic [W-1:0]         add_sum,
   input  logic                 add_cout,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W*WORDS-1:0]   out_sum,
   output logic                 out_cout
);

   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int N  = W * WORDS;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q;
   logic [IW-1:0]   idx_q;
   logic            carry_q;
   logic [N-1:0]    a_q;
   logic [N-1:0]    b_q;
   logic [N-1:0]    sum_q;
   logic            cout_q;
   logic            valid_q;

   logic [N-1:0]    b_load_d;
   logic            carry_load_d;
   logic [W-1:0]    a_slice [WORDS];
   logic [W-1:0]    b_slice [WORDS];

   for (genvar gi = 0; gi < WORDS; gi++) begin : g_slice
      assign a_slice[gi] = a_q[gi*W +: W];
      assign b_slice[gi] = b_q[gi*W +: W];
   end

`ifdef WIDE_ADD_SUB_EN
   // Subtraction is A + ~B + 1; the caller's carry-in is irrelevant then.
   assign b_load_d     = in_sub ? ~in_b : in_b;
   assign carry_load_d = in_sub | in_cin;
`else
   assign b_load_d     = in_b;
   assign carry_load_d = in_cin;
`endif

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = valid_q;
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;

   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state_q == RUN) begin
         add_a   = a_slice[idx_q];
         add_b   = b_slice[idx_q];
         add_cin = carry_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= in_a;
                  b_q     <= b_load_d;
                  carry_q <= carry_load_d;
                  idx_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sum_q[idx_q*W +: W] <= add_sum;
               carry_q             <= add_cout;
               // idx parks on the last slice rather than wrapping.
               if (idx_q == IW'(WORDS - 1)) begin
                  cout_q  <= add_cout;
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq with a behavioural 32-bit adder and a result scoreboard.
module tb_wide_add_seq;

   localparam int WORDS = 4;
   localparam int W     = 32;
   localparam int N     = W * WORDS;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [N-1:0]   in_a = '0;
   logic [N-1:0]   in_b = '0;
   logic           in_cin = 1'b0;
   logic           in_sub = 1'b0;
   logic [W-1:0]   add_a;
   logic [W-1:0]   add_b;
   logic           add_cin;
   logic [W-1:0]   add_sum;
   logic           add_cout;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [N-1:0]   out_sum;
   logic           out_cout;

   int n_cmp = 0;
   int n_err = 0;
   int cyc_cnt = 0;
   logic [N:0] sb [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt++;

   // Stand-in for the external 32-bit adder.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

   wide_add_seq #(.WORDS(WORDS), .W(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef WIDE_ADD_SUB_EN
      .in_sub(in_sub),
`endif
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout)
   );

   function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic cin, input logic sub);
      if (sub) return {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
      return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
   endfunction

   function automatic logic [N-1:0] rand_wide();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Presents a request until accepted; returns just after the accepting edge.
   task automatic do_accept(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                            input logic sub, output int acc_cyc);
      bit ok = 1'b0;
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      acc_cyc = cyc_cnt;
      if (ok) begin
         sb.push_back(ref_add(a, b, cin, in_sub));
      end else begin
         n_cmp++; n_err++;
         $display("FAIL accept_timeout: in_ready=%b required 1 within 100 cycles", in_ready);
      end
   endtask

   // Returns on the first negedge with out_valid high; lat counts the low negedges before it.
   task automatic wait_valid(output int lat);
      lat = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (out_valid) return;
         lat++;
      end
      n_cmp++; n_err++;
      $display("FAIL valid_timeout: out_valid=%b required 1 within 200 cycles", out_valid);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
      n_cmp++; if (out_sum !== '0 || out_cout !== 1'b0) begin n_err++; $display("FAIL reset_out: got %h/%b exp 0/0", out_sum, out_cout); end
      n_cmp++; if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin n_err++; $display("FAIL reset_add: got %h/%h/%b exp 0", add_a, add_b, add_cin); end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready: got %b exp 1", in_ready); end
      @(posedge clk);
      #1;
      $display("txn reset: done");
   endtask

   task automatic test_carry_chain();
      logic [N-1:0] a = '1;
      logic [N-1:0] b = N'(1);
      logic [N:0]   exp;
      int c;
      do_accept(a, b, 1'b0, 1'b0, c);
      for (int k = 0; k < WORDS; k++) begin
         @(negedge clk);
         n_cmp++; if (add_a !== a[k*W +: W] || add_b !== b[k*W +: W]) begin
            n_err++; $display("FAIL chain_slice%0d: got a=%h b=%h exp a=%h b=%h", k, add_a, add_b, a[k*W +: W], b[k*W +: W]);
         end
         n_cmp++; if (add_cin !== (k != 0)) begin n_err++; $display("FAIL chain_cin%0d: got %b exp %b", k, add_cin, (k != 0)); end
         n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL chain_early_valid%0d: got %b exp 0", k, out_valid); end
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL chain_latency: out_valid=%b exp 1 at %0d cycles", out_valid, WORDS); end
      exp = sb.pop_front();
      n_cmp++; if ({out_cout, out_sum} !== exp || out_sum !== '0 || out_cout !== 1'b1) begin
         n_err++; $display("FAIL chain_result: got %b_%h exp %b_%h", out_cout, out_sum, exp[N], exp[N-1:0]);
      end
      $display("txn carry_chain: sum=%h cout=%b", out_sum, out_cout);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL chain_drain: valid=%b ready=%b exp 0/1", out_valid, in_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_slice_carry();
      logic [N:0] exp;
      int c, lat;
      do_accept(N'(64'h1_FFFF_FFFF), N'(1), 1'b0, 1'b0, c);
      wait_valid(lat);
      n_cmp++; if (lat != WORDS) begin n_err++; $display("FAIL slice_latency: got %0d exp %0d", lat, WORDS); end
      exp = sb.pop_front();
      n_cmp++; if (out_sum[31:0] !== 32'h0 || out_sum[63:32] !== 32'h2 || out_sum[127:64] !== 64'h0 || out_cout !== 1'b0) begin
         n_err++; $display("FAIL slice_values: got %b_%h exp 0_...0002_00000000", out_cout, out_sum);
      end
      n_cmp++; if ({out_cout, out_sum} !== exp) begin n_err++; $display("FAIL slice_result: got %b_%h exp %b_%h", out_cout, out_sum, exp[N], exp[N-1:0]); end
      $display("txn slice_carry: sum=%h cout=%b", out_sum, out_cout);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [N:0] exp;
      logic [N-1:0] a2 = rand_wide();
      logic [N-1:0] b2 = rand_wide();
      int c, lat;
      do_accept(rand_wide(), rand_wide(), 1'b1, 1'b0, c);
      wait_valid(lat);
      exp = sb.pop_front();
      // A second request waits on in_valid for the whole stall and must not be taken.
      in_a = a2; in_b = b2; in_cin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         n_cmp++; if (out_valid !== 1'b1 || {out_cout, out_sum} !== exp || in_ready !== 1'b0) begin
            n_err++; $display("FAIL hold%0d: valid=%b ready=%b res=%b_%h exp 1/0/%b_%h", i, out_valid, in_ready, out_cout, out_sum, exp[N], exp[N-1:0]);
         end
         @(posedge clk);
         @(negedge clk);
      end
      $display("txn backpressure_hold: sum=%h cout=%b", out_sum, out_cout);
      out_ready = 1'b1;
      do_accept(a2, b2, 1'b0, 1'b0, c);
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release: out_valid=%b exp 0", out_valid); end
      wait_valid(lat);
      exp = sb.pop_front();
      n_cmp++; if ({out_cout, out_sum} !== exp) begin n_err++; $display("FAIL hold_next: got %b_%h exp %b_%h", out_cout, out_sum, exp[N], exp[N-1:0]); end
      $display("txn backpressure_next: sum=%h cout=%b", out_sum, out_cout);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [N:0] exp;
      int c1, c2, lat;
      do_accept(rand_wide(), rand_wide(), 1'b0, 1'b0, c1);
      wait_valid(lat);
      exp = sb.pop_front();
      n_cmp++; if ({out_cout, out_sum} !== exp) begin n_err++; $display("FAIL b2b_first: got %b_%h exp %b_%h", out_cout, out_sum, exp[N], exp[N-1:0]); end
      $display("txn back_to_back_1: sum=%h cout=%b", out_sum, out_cout);
      out_ready = 1'b1;
      do_accept(rand_wide(), rand_wide(), 1'b1, 1'b0, c2);
      n_cmp++; if (c2 - c1 != WORDS + 2) begin n_err++; $display("FAIL b2b_interval: got %0d exp %0d", c2 - c1, WORDS + 2); end
      wait_valid(lat);
      exp = sb.pop_front();
      n_cmp++; if ({out_cout, out_sum} !== exp) begin n_err++; $display("FAIL b2b_second: got %b_%h exp %b_%h", out_cout, out_sum, exp[N], exp[N-1:0]); end
      $display("txn back_to_back_2: sum=%h cout=%b", out_sum, out_cout);
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset_abort();
      logic [N:0] exp;
      logic [N-1:0] a = rand_wide();
      int c, lat;
      do_accept(a, rand_wide(), 1'b0, 1'b0, c);
      repeat (2) begin
         @(negedge clk);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      n_cmp++; if (add_a !== a[2*W +: W]) begin n_err++; $display("FAIL abort_idx2: add_a=%h exp %h", add_a, a[2*W +: W]); end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      void'(sb.pop_back());
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0) begin
            n_err++; $display("FAIL abort_idle%0d: valid=%b ready=%b sum=%h exp 0/1/0", i, out_valid, in_ready, out_sum);
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b0;
      do_accept(N'(5), N'(7), 1'b0, 1'b0, c);
      wait_valid(lat);
      exp = sb.pop_front();
      n_cmp++; if (out_sum !== N'(12) || out_cout !== 1'b0 || {out_cout, out_sum} !== exp) begin
         n_err++; $display("FAIL abort_next: got %b_%h exp 0_%h", out_cout, out_sum, N'(12));
      end
      $display("txn reset_abort_next: sum=%h cout=%b", out_sum, out_cout);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [N-1:0] ra, rb;
      logic rc, rs;
      logic [N:0] exp;
      bit have = 1'b0;
      int sent = 0, recv = 0;
      for (int cyc = 0; cyc < 20000 && recv < 200; cyc++) begin
         if (!have && sent < 200) begin
            ra = rand_wide();
            rb = ($urandom_range(0, 3) == 0) ? ~ra : rand_wide();
            rc = 1'($urandom_range(0, 1));
`ifdef WIDE_ADD_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            have = 1'b1;
         end
         in_a = ra; in_b = rb; in_cin = rc; in_sub = rs;
         in_valid  = have && ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (in_valid && in_ready) begin
            sb.push_back(ref_add(ra, rb, rc, in_sub));
            sent++;
            have = 1'b0;
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL rand_extra: unexpected result %b_%h, exp none", out_cout, out_sum);
            end else begin
               exp = sb.pop_front();
               if ({out_cout, out_sum} !== exp) begin
                  n_err++; $display("FAIL rand_%0d: got %b_%h exp %b_%h", recv, out_cout, out_sum, exp[N], exp[N-1:0]);
               end
            end
            $display("txn rand_%0d: sum=%h cout=%b", recv, out_sum, out_cout);
            recv++;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      n_cmp++; if (recv != 200 || sent != 200 || sb.size() != 0) begin
         n_err++; $display("FAIL rand_count: sent=%0d recv=%0d pending=%0d exp 200/200/0", sent, recv, sb.size());
      end
   endtask

`ifdef WIDE_ADD_SUB_EN
   task automatic test_sub();
      logic [N-1:0] exp_sum = '1;
      logic [N:0] exp;
      int c, lat;
      exp_sum[0] = 1'b0;
      do_accept(N'(3), N'(5), 1'b0, 1'b1, c);
      wait_valid(lat);
      exp = sb.pop_front();
      n_cmp++; if (out_sum !== exp_sum || out_cout !== 1'b0 || {out_cout, out_sum} !== exp) begin
         n_err++; $display("FAIL sub_3m5: got %b_%h exp 0_%h", out_cout, out_sum, exp_sum);
      end
      $display("txn sub_3m5: sum=%h cout=%b", out_sum, out_cout);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      do_accept(N'(5), N'(3), 1'b1, 1'b1, c);
      wait_valid(lat);
      exp = sb.pop_front();
      n_cmp++; if (out_sum !== N'(2) || out_cout !== 1'b1 || {out_cout, out_sum} !== exp) begin
         n_err++; $display("FAIL sub_5m3: got %b_%h exp 1_%h", out_cout, out_sum, N'(2));
      end
      $display("txn sub_5m3: sum=%h cout=%b", out_sum, out_cout);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_carry_chain();
      test_slice_carry();
      test_backpressure();
      test_back_to_back();
      test_reset_abort();
`ifdef WIDE_ADD_SUB_EN
      test_sub();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
